// File: rtl/dram_arb_pkg.sv
// Shared constants and state encoding for the MIG app-interface arbiter.
package dram_arb_pkg;

    localparam int APP_ADDR_W = 28;
    localparam int APP_DATA_W = 128;
    localparam int APP_MASK_W = 16;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_CMD,
        RD_WAIT,
        DONE
    } arb_state_e;

endpackage

// File: rtl/m_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the pointer,
// searching in increasing order with wrap-around.
module m_rr_pick #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 valid_o
);

    always_comb begin : pick
        int   cand;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        cand  = 0;
        found = 1'b0;
        // Offset NUM_PORTS lands back on the pointer itself, so it has lowest priority.
        for (int off = 1; off <= NUM_PORTS; off++) begin
            cand = (int'(ptr_i) + off) % NUM_PORTS;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/m_dram_arb.sv
// Round-robin sequencer sharing one MIG 7-series app interface, one transaction at a time.
// Optional read-wait watchdog enabled by defining DRAM_ARB_TIMEOUT_EN.
module m_dram_arb
    import dram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic                            ui_clk,
    input  logic                            ui_clk_sync_rst,
    input  logic                            init_calib_complete,
    input  logic [NUM_PORTS-1:0]            i_req,
    input  logic [NUM_PORTS-1:0]            i_cmd,
    input  logic [NUM_PORTS*APP_ADDR_W-1:0] i_addr,
    input  logic [NUM_PORTS*APP_DATA_W-1:0] i_wdata,
    input  logic [NUM_PORTS*APP_MASK_W-1:0] i_wmask,
    output logic [NUM_PORTS-1:0]            o_done,
    output logic [APP_DATA_W-1:0]           o_rdata,
    output logic                            o_err,
    output logic [APP_ADDR_W-1:0]           app_addr,
    output logic [2:0]                      app_cmd,
    output logic                            app_en,
    input  logic                            app_rdy,
    output logic [APP_DATA_W-1:0]           app_wdf_data,
    output logic [APP_MASK_W-1:0]           app_wdf_mask,
    output logic                            app_wdf_wren,
    output logic                            app_wdf_end,
    input  logic                            app_wdf_rdy,
    input  logic [APP_DATA_W-1:0]           app_rd_data,
    input  logic                            app_rd_data_valid
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [APP_ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]             cmd_q, cmd_d;
    logic                   en_q, en_d;
    logic [APP_DATA_W-1:0]  wdata_q, wdata_d;
    logic [APP_MASK_W-1:0]  wmask_q, wmask_d;
    logic                   wren_q, wren_d;
    logic [NUM_PORTS-1:0]   done_q, done_d;
    logic [APP_DATA_W-1:0]  rdata_q, rdata_d;

    logic [NUM_PORTS-1:0]   pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;

`ifdef DRAM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   err_q, err_d;
`endif

    m_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req_i   (i_req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        en_d    = en_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wren_d  = wren_q;
        done_d  = '0;
        rdata_d = rdata_q;
`ifdef DRAM_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (init_calib_complete && pick_valid) begin
                    ptr_d   = pick_idx;
                    gnt_d   = pick_gnt;
                    addr_d  = i_addr[pick_idx*APP_ADDR_W +: APP_ADDR_W];
                    wdata_d = i_wdata[pick_idx*APP_DATA_W +: APP_DATA_W];
                    wmask_d = i_wmask[pick_idx*APP_MASK_W +: APP_MASK_W];
                    en_d    = 1'b1;
                    if (i_cmd[pick_idx]) begin
                        cmd_d   = APP_CMD_READ;
                        state_d = RD_CMD;
                    end else begin
                        cmd_d   = APP_CMD_WRITE;
                        wren_d  = 1'b1;
                        state_d = WR;
                    end
                end
            end
            // Command and write-data channels retire independently; leave once both have.
            WR: begin
                en_d   = en_q & ~app_rdy;
                wren_d = wren_q & ~app_wdf_rdy;
                if (!en_d && !wren_d) begin
                    done_d  = gnt_q;
                    state_d = DONE;
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    en_d    = 1'b0;
                    state_d = RD_WAIT;
`ifdef DRAM_ARB_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    rdata_d = app_rd_data;
                    done_d  = gnt_q;
                    state_d = DONE;
                end
`ifdef DRAM_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    done_d  = gnt_q;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset discards any in-flight MIG transaction; the pointer favours port 0 first.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(NUM_PORTS - 1);
            gnt_q   <= '0;
            addr_q  <= '0;
            cmd_q   <= APP_CMD_WRITE;
            en_q    <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            wren_q  <= 1'b0;
            done_q  <= '0;
            rdata_q <= '0;
`ifdef DRAM_ARB_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            en_q    <= en_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef DRAM_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign app_addr     = addr_q;
    assign app_cmd      = cmd_q;
    assign app_en       = en_q;
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = wmask_q;
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = wren_q;
    assign o_done       = done_q;
    assign o_rdata      = rdata_q;
`ifdef DRAM_ARB_TIMEOUT_EN
    assign o_err        = err_q;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_m_dram_arb.sv
// Directed bench for m_dram_arb with a small MIG memory model and a transaction scoreboard.
// The timeout scenario runs only when DRAM_ARB_TIMEOUT_EN is defined.
module tb_m_dram_arb;

    localparam int NP  = 2;
    localparam int TMO = 16;

    localparam logic [127:0] D_A = 128'h8899AABBCCDDEEFF0011223344556677;
    localparam logic [127:0] D_B = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
    localparam logic [127:0] R_0 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] R_1 = 128'h55555555_66666666_77777777_88888888;

    logic              ui_clk = 1'b0;
    logic              ui_clk_sync_rst;
    logic              init_calib_complete;
    logic [NP-1:0]     i_req;
    logic [NP-1:0]     i_cmd;
    logic [NP*28-1:0]  i_addr;
    logic [NP*128-1:0] i_wdata;
    logic [NP*16-1:0]  i_wmask;
    logic [NP-1:0]     o_done;
    logic [127:0]      o_rdata;
    logic              o_err;
    logic [27:0]       app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [127:0]      app_wdf_data;
    logic [15:0]       app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic [127:0]      app_rd_data;
    logic              app_rd_data_valid;

    typedef struct {
        int           port;
        bit           isRead;
        logic [27:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  wmask;
        logic [127:0] rdata;
        logic         err;
    } exp_t;

    exp_t         expQ[$];
    logic [127:0] mem [logic [27:0]];
    int           nChecks     = 0;
    int           nFails      = 0;
    int           doneCount   = 0;
    int           readLatency = 2;
    int           rdPend      = 0;
    logic [27:0]  rdAddr      = '0;
    logic [NP-1:0] holdReq    = '0;

    always #5 ui_clk = ~ui_clk;

    m_dram_arb #(
        .NUM_PORTS (NP),
        .TIMEOUT   (TMO)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .i_req               (i_req),
        .i_cmd               (i_cmd),
        .i_addr              (i_addr),
        .i_wdata             (i_wdata),
        .i_wmask             (i_wmask),
        .o_done              (o_done),
        .o_rdata             (o_rdata),
        .o_err               (o_err),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid)
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input int port, input bit isRead, input logic [27:0] addr,
                           input logic [127:0] wdata, input logic [15:0] wmask,
                           input logic [127:0] rdata, input logic err);
        exp_t e;
        e.port   = port;
        e.isRead = isRead;
        e.addr   = addr;
        e.wdata  = wdata;
        e.wmask  = wmask;
        e.rdata  = rdata;
        e.err    = err;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int port, input bit isRead, input logic [27:0] addr,
                                 input logic [127:0] wdata, input logic [15:0] wmask,
                                 input logic [127:0] rdata, input logic err);
        i_cmd[port]            = isRead;
        i_addr[port*28 +: 28]  = addr;
        i_wdata[port*128 +: 128] = wdata;
        i_wmask[port*16 +: 16] = wmask;
        i_req[port]            = 1'b1;
        pushExp(port, isRead, addr, wdata, wmask, rdata, err);
    endtask

    // sel 0 waits for app_en, sel 1 waits for any o_done; returns on that negedge.
    task automatic waitSignal(input string tag, input int sel, input int maxCyc);
        logic got;
        got = 1'b0;
        for (int i = 0; i < maxCyc && !got; i++) begin
            @(negedge ui_clk);
            got = (sel == 0) ? app_en : (o_done != '0);
        end
        checkOutput(tag, got, 1'b1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_app_en"}, app_en, 1'b0);
        checkOutput({tag, "_wren"}, app_wdf_wren, 1'b0);
        checkOutput({tag, "_wend"}, app_wdf_end, 1'b0);
        checkOutput({tag, "_done"}, o_done, '0);
        checkOutput({tag, "_err"}, o_err, 1'b0);
        checkOutput({tag, "_rdata"}, o_rdata, '0);
        checkOutput({tag, "_addr"}, app_addr, '0);
        checkOutput({tag, "_cmd"}, app_cmd, 3'b000);
        checkOutput({tag, "_wdata"}, app_wdf_data, '0);
        checkOutput({tag, "_wmask"}, app_wdf_mask, '0);
    endtask

    // MIG model, requester drop rule and scoreboard, evaluated once per cycle on the falling edge.
    task automatic migStep();
        exp_t         e;
        logic [127:0] cur;
        if (o_done != '0) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", o_done, '0);
            end else begin
                e = expQ.pop_front();
                checkOutput("donePort", o_done, 128'(1) << e.port);
                checkOutput("doneErr", o_err, e.err);
                if (e.isRead) checkOutput("doneRdata", o_rdata, e.rdata);
            end
            for (int k = 0; k < NP; k++) begin
                if (o_done[k] && !holdReq[k]) i_req[k] = 1'b0;
            end
        end
        if (app_rd_data_valid) app_rd_data_valid = 1'b0;
        if (rdPend > 0) begin
            rdPend--;
            if (rdPend == 0) begin
                app_rd_data       = mem.exists(rdAddr) ? mem[rdAddr] : '0;
                app_rd_data_valid = 1'b1;
            end
        end
        if (app_en && app_rdy) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedCmd", app_en, 1'b0);
            end else begin
                checkOutput("cmdAddr", app_addr, expQ[0].addr);
                checkOutput("cmdOp", app_cmd, expQ[0].isRead ? 3'b001 : 3'b000);
            end
            if (app_cmd == 3'b001 && readLatency > 0) begin
                rdPend = readLatency;
                rdAddr = app_addr;
            end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
            if (expQ.size() != 0) begin
                checkOutput("wdfData", app_wdf_data, expQ[0].wdata);
                checkOutput("wdfMask", app_wdf_mask, expQ[0].wmask);
            end
            checkOutput("wdfEnd", app_wdf_end, 1'b1);
            cur = mem.exists(app_addr) ? mem[app_addr] : '0;
            for (int b = 0; b < 16; b++) begin
                if (!app_wdf_mask[b]) cur[b*8 +: 8] = app_wdf_data[b*8 +: 8];
            end
            mem[app_addr] = cur;
        end
    endtask

    initial begin
        forever begin
            @(negedge ui_clk);
            migStep();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  enCnt, wrenCnt, cyc, lastWren, doneCyc, nSeen, startCnt;
        logic enSeen;

        ui_clk_sync_rst     = 1'b1;
        init_calib_complete = 1'b0;
        i_req               = '0;
        i_cmd               = '0;
        i_addr              = '0;
        i_wdata             = '0;
        i_wmask             = '0;
        app_rdy             = 1'b1;
        app_wdf_rdy         = 1'b1;
        app_rd_data         = '0;
        app_rd_data_valid   = 1'b0;

        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        checkResetValues("reset");
        @(posedge ui_clk); #1;
        ui_clk_sync_rst = 1'b0;

        // Write held off by calibration, then granted one cycle after calib rises.
        applyStimulus(0, 1'b0, 28'h40, D_A, 16'h0000, '0, 1'b0);
        enSeen = 1'b0;
        repeat (20) begin
            @(negedge ui_clk);
            if (app_en) enSeen = 1'b1;
        end
        checkOutput("calibHold", enSeen, 1'b0);
        @(posedge ui_clk); #1;
        init_calib_complete = 1'b1;
        @(negedge ui_clk);
        checkOutput("calibSameCycle", app_en, 1'b0);
        @(negedge ui_clk);
        checkOutput("calibGrant", app_en, 1'b1);
        checkOutput("wrWren", app_wdf_wren, 1'b1);
        @(negedge ui_clk);
        checkOutput("wrBestDone", o_done, 2'b01);
        @(negedge ui_clk);
        checkOutput("wrDonePulse", o_done, 2'b00);

        // Read back the same address.
        @(posedge ui_clk); #1;
        readLatency = 3;
        applyStimulus(0, 1'b1, 28'h40, '0, 16'h0000, D_A, 1'b0);
        waitSignal("rdBackDone", 1, 40);
        repeat (2) @(posedge ui_clk); #1;
        checkOutput("doneCountWrRd", doneCount, 2);

        // Write-data channel stalled for five cycles while the command is accepted at once.
        app_wdf_rdy = 1'b0;
        applyStimulus(1, 1'b0, 28'h80, D_B, 16'h00F0, '0, 1'b0);
        enCnt = 0; wrenCnt = 0; cyc = 0; lastWren = -1; doneCyc = -1;
        while (doneCyc < 0 && cyc < 40) begin
            @(negedge ui_clk);
            cyc++;
            if (app_en) enCnt++;
            if (app_wdf_wren) begin
                wrenCnt++;
                lastWren = cyc;
            end
            if (o_done != '0) doneCyc = cyc;
            if (wrenCnt == 5 && !app_wdf_rdy) begin
                @(posedge ui_clk); #1;
                app_wdf_rdy = 1'b1;
            end
        end
        checkOutput("stallEnCycles", enCnt, 1);
        checkOutput("stallWrenCycles", wrenCnt, 6);
        checkOutput("stallDoneAfterWdf", doneCyc, lastWren + 1);

        // Two ports holding reads continuously must alternate 0,1,0,1.
        @(posedge ui_clk); #1;
        mem[28'h100] = R_0;
        mem[28'h200] = R_1;
        readLatency  = 2;
        holdReq      = 2'b11;
        startCnt     = doneCount;
        applyStimulus(0, 1'b1, 28'h100, '0, 16'h0000, R_0, 1'b0);
        applyStimulus(1, 1'b1, 28'h200, '0, 16'h0000, R_1, 1'b0);
        pushExp(0, 1'b1, 28'h100, '0, 16'h0000, R_0, 1'b0);
        pushExp(1, 1'b1, 28'h200, '0, 16'h0000, R_1, 1'b0);
        nSeen = 0;
        for (int i = 0; i < 200 && nSeen < 4; i++) begin
            @(negedge ui_clk);
            if (o_done != '0) nSeen++;
            if (nSeen == 4) begin
                i_req   = '0;
                holdReq = '0;
            end
        end
        checkOutput("altGrants", nSeen, 4);
        repeat (6) @(negedge ui_clk);
        checkOutput("altDoneCount", doneCount - startCnt, 4);
        checkOutput("altQueueEmpty", expQ.size(), 0);

        // Reset while waiting for read data; the late data must not complete anything.
        @(posedge ui_clk); #1;
        readLatency = 8;
        applyStimulus(0, 1'b1, 28'h40, D_B, 16'hFFFF, D_A, 1'b0);
        waitSignal("rstGrant", 0, 20);
        @(negedge ui_clk);
        @(posedge ui_clk); #1;
        ui_clk_sync_rst = 1'b1;
        i_req           = '0;
        @(posedge ui_clk); #1;
        @(negedge ui_clk);
        checkResetValues("midRst");
        @(posedge ui_clk); #1;
        ui_clk_sync_rst = 1'b0;
        expQ.delete();
        startCnt = doneCount;
        repeat (12) @(negedge ui_clk);
        checkOutput("strayNoDone", doneCount - startCnt, 0);

`ifdef DRAM_ARB_TIMEOUT_EN
        // Normal read first so o_rdata holds non-zero data before the timeout clears it.
        @(posedge ui_clk); #1;
        readLatency = 2;
        applyStimulus(0, 1'b1, 28'h100, '0, 16'h0000, R_0, 1'b0);
        waitSignal("preTmoDone", 1, 40);
        @(posedge ui_clk); #1;
        readLatency = 0;
        applyStimulus(1, 1'b1, 28'h200, '0, 16'h0000, '0, 1'b1);
        waitSignal("tmoGrant", 0, 20);
        cyc = 0;
        doneCyc = -1;
        while (doneCyc < 0 && cyc < 60) begin
            @(negedge ui_clk);
            cyc++;
            if (o_done != '0) doneCyc = cyc;
        end
        checkOutput("tmoLatency", doneCyc, TMO + 1);
        repeat (3) @(negedge ui_clk);
        checkOutput("tmoQueueEmpty", expQ.size(), 0);
`endif

        repeat (3) @(negedge ui_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
